// File: rtl/piso_tx_pkg.sv
// Shared types and helpers for the PISO transmit controller.
//   state_e : controller state, 2-bit encoding
//   cnt_w() : counter width for a count range of n (never below 1 bit)
package piso_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, left-shifting register; exposes only the MSB.
//   clk, rst : clock, async active-high clear
//   load     : capture d (wins over shift)
//   shift    : shift left by one, zero fill
//   d        : parallel load word
//   q_msb    : current MSB
module piso_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load)       data_d = d;
    else if (shift) data_d = {data_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q_msb = data_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Sequencer for a parallel-in/serial-out transmitter. Accepts a WIDTH-bit
// word on a valid/ready handshake and sends it MSB-first, each bit held for
// DIV clocks, followed by a one-cycle frame_done pulse.
// Optional build macro PISO_TX_PARITY_EN appends an even-parity bit.
//   clk, rst          : clock, async active-high reset
//   in_valid/in_ready : word handshake (ready only in IDLE)
//   in_data           : parallel word, sampled at the handshake only
//   abort             : cancels a frame in SHIFT/PAR, no frame_done
//   ser_out/ser_valid : serial bit and its qualifier
//   busy              : any state other than IDLE
//   frame_done        : one-cycle pulse after the last bit
module piso_tx_ctrl
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int BIT_W = cnt_w(WIDTH);
  localparam int DIV_W = cnt_w(DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             load, shift, msb;
`ifdef PISO_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (in_data),
    .q_msb (msb)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
`ifdef PISO_TX_PARITY_EN
    par_d      = par_q;
`endif
    load       = 1'b0;
    shift      = 1'b0;
    in_ready   = 1'b0;
    ser_valid  = 1'b0;
    ser_out    = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          bit_cnt_d = BIT_LAST;
          div_cnt_d = DIV_LAST;
`ifdef PISO_TX_PARITY_EN
          par_d     = ^in_data;
`endif
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = msb;
        // abort takes precedence over any bit boundary in the same cycle
        if (abort) begin
          state_d = ST_IDLE;
        end else if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end else begin
          div_cnt_d = DIV_LAST;
          if (bit_cnt_q != '0) begin
            shift     = 1'b1;
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
          end else begin
`ifdef PISO_TX_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef PISO_TX_PARITY_EN
      ST_PAR: begin
        ser_valid = 1'b1;
        ser_out   = par_q;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end else begin
          div_cnt_d = DIV_LAST;
          state_d   = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
`ifdef PISO_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
`ifdef PISO_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: doc/piso_tx_ctrl.md
Name: piso_tx_ctrl

Overview:
- Sequencer for a parallel-in/serial-out shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake, loads it, and shifts it out MSB-first, holding each bit for DIV clocks.
- Signals frame completion with a one-cycle pulse.
- Sits between a parallel producer (register file / FIFO) and a serial line driver.

Parameters:
- WIDTH, 4, data word width in bits (>=2)
- DIV, 1, clocks per serial bit (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  producer has a word
- in_data  input  WIDTH  parallel word
- in_ready  output  1  controller can accept a word
- abort  input  1  synchronous frame cancel
- ser_out  output  1  serial data, MSB first
- ser_valid  output  1  ser_out carries a frame bit
- busy  output  1  frame in progress (any state other than IDLE)
- frame_done  output  1  one-cycle pulse after the last bit

Behaviour:
- Reset is asynchronous, active-high, clock clk. All state registers are cleared.
  - State returns to IDLE.
  - in_ready=1; ser_out=0, ser_valid=0, busy=0, frame_done=0.
  - Shift register and all counters are cleared.
- States: IDLE, SHIFT, PAR (only with the optional feature), DONE.
- IDLE:
  - in_ready=1, ser_valid=0, ser_out=0.
  - A handshake is in_valid && in_ready at a rising edge (cycle T).
  - On handshake: load in_data into the shift register, set bit_cnt=WIDTH-1 and div_cnt=DIV-1, go to SHIFT.
- SHIFT:
  - in_ready=0, ser_valid=1, ser_out = shift register MSB.
  - The first bit is visible in cycle T+1.
  - Each cycle: if div_cnt>0, decrement it. Otherwise reload div_cnt=DIV-1 and then:
    - if bit_cnt>0: shift left by one (zero fill) and decrement bit_cnt;
    - if bit_cnt==0: go to PAR if the feature is enabled, else DONE.
- DONE:
  - frame_done=1, ser_valid=0, in_ready=0 for exactly one cycle, then IDLE.
  - frame_done is asserted in cycle T+WIDTH*DIV+1 (+DIV with parity).
- Back-to-back frames:
  - The earliest next handshake is at cycle T+WIDTH*DIV+2 (the first IDLE cycle).
  - Minimum inter-frame gap is one idle cycle.
- in_valid while busy: ignored; in_data is not sampled; no state change.
- abort:
  - Sampled in SHIFT or PAR: go to IDLE next cycle; ser_valid drops; no frame_done.
  - Ignored in IDLE and DONE.
  - abort together with a DIV-boundary in the same cycle: abort wins.
- in_data changing after the handshake has no effect on the frame in progress.
- Width rules:
  - bit_cnt is $clog2(WIDTH) bits.
  - div_cnt is max(1,$clog2(DIV)) bits.
  - With DIV=1, div_cnt stays 0 and a shift occurs every cycle.
- Reset mid-frame: immediate return to the reset values above; a partial frame is never completed.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- When defined:
  - At the handshake, even parity (XOR of in_data) is captured.
  - After the last data bit, state PAR drives ser_out=parity, ser_valid=1 for DIV cycles, then DONE.
  - Frame length is WIDTH+1 bits.
- When undefined: no PAR state and no parity register; SHIFT goes directly to DONE.

Decomposition:
- Package piso_tx_pkg holds:
  - state enum type (IDLE, SHIFT, PAR, DONE) with 2-bit encoding;
  - function for counter-width computation.
- One sub-module, piso_shreg (WIDTH parameter):
  - ports: clk, rst, load, shift, d[WIDTH-1:0], q_msb;
  - async clear; load has priority over shift.
- piso_tx_ctrl instantiates piso_shreg and owns the FSM, counters and parity.

Test Plan:
- WIDTH=4, DIV=1, handshake at T with in_data=4'b1011:
  - ser_out = 1,0,1,1 in T+1..T+4 with ser_valid=1;
  - frame_done=1 in T+5 only; in_ready=1 at T+6.
- WIDTH=4, DIV=3, in_data=4'b0110:
  - each bit held 3 cycles: 0,0,0,1,1,1,1,1,1,0,0,0 over T+1..T+12;
  - frame_done at T+13.
- PISO_TX_PARITY_EN defined, WIDTH=4, DIV=1, in_data=4'b1011:
  - data bits, then parity bit 1 at T+5;
  - frame_done at T+6.
- in_valid held high with a new in_data=4'b0000 during the 4'b1011 frame:
  - first frame is unchanged;
  - second handshake occurs at T+6, sending 0,0,0,0.
- abort asserted in cycle T+2 (DIV=1):
  - ser_valid=0 and in_ready=1 from T+3;
  - frame_done never pulses.
- rst asserted asynchronously mid-SHIFT:
  - all outputs at reset values immediately;
  - after release, a new handshake with 4'b1001 transmits correctly.
